// File: rtl/gray_stream_feeder_if.sv
// Pixel stream bundle between the RGB source, the feeder and the Sobel controller.
// The feeder sits on the slave side; the source/consumer pair sits on the master side.
interface gray_stream_feeder_if #(
    parameter int PIXEL_WIDTH_IN  = 24,
    parameter int PIXEL_WIDTH_OUT = 8
);
    logic                       frame_start_i;
    logic [PIXEL_WIDTH_IN-1:0]  px_rgb_i;
    logic                       px_valid_i;
    logic                       px_ready_o;
    logic [PIXEL_WIDTH_OUT-1:0] px_gray_o;
    logic                       gray_valid_o;
    logic                       sobel_start_o;
    logic                       frame_done_o;

    modport master (
        output frame_start_i, px_rgb_i, px_valid_i,
        input  px_ready_o, px_gray_o, gray_valid_o,
        input  sobel_start_o, frame_done_o
    );

    modport slave (
        input  frame_start_i, px_rgb_i, px_valid_i,
        output px_ready_o, px_gray_o, gray_valid_o,
        output sobel_start_o, frame_done_o
    );
endinterface

// File: rtl/gray_stream_feeder.sv
// RGB to 8-bit luminance feeder with frame tracking and pipeline drain.
// Define GRAY_ROUND_EN for round-to-nearest instead of truncation.
module gray_stream_feeder #(
    parameter  int PIXEL_WIDTH_IN  = 24,
    parameter  int PIXEL_WIDTH_OUT = 8,
    parameter  int FRAME_PIXELS    = 64,
    localparam int CNT_BITS        = $clog2(FRAME_PIXELS + 1)
) (
    input  logic           clk_i,
    input  logic           nreset_i,
    gray_stream_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CNT_BITS-1:0] FRAME_END  = CNT_BITS'(FRAME_PIXELS);
    localparam logic [CNT_BITS-1:0] FRAME_LAST = CNT_BITS'(FRAME_PIXELS - 1);

    state_t                     state;
    logic [CNT_BITS-1:0]        count;
    logic                       flush_cnt;
    logic                       frame_done;

    logic [15:0]                pr;
    logic [15:0]                pg;
    logic [15:0]                pb;
    logic                       v1;
    logic [16:0]                sum;
    logic [PIXEL_WIDTH_OUT-1:0] gray;
    logic [PIXEL_WIDTH_OUT-1:0] px_gray;
    logic                       gray_valid;
    logic                       sobel_start;

    logic                       px_ready;
    logic                       transfer;
    logic [7:0]                 r;
    logic [7:0]                 g;
    logic [7:0]                 b;

    assign r = bus.px_rgb_i[PIXEL_WIDTH_IN-1 -: 8];
    assign g = bus.px_rgb_i[15:8];
    assign b = bus.px_rgb_i[7:0];

    // Ready falls as soon as the last pixel is counted, never a cycle late.
    assign px_ready = (state == STREAM) && (count != FRAME_END);
    assign transfer = bus.px_valid_i & px_ready;

`ifdef GRAY_ROUND_EN
    assign sum = {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + 17'd128;
`else
    assign sum = {1'b0, pr} + {1'b0, pg} + {1'b0, pb};
`endif
    assign gray = PIXEL_WIDTH_OUT'(sum >> 8);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state      <= IDLE;
            count      <= '0;
            flush_cnt  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    count     <= '0;
                    flush_cnt <= 1'b0;
                    if (bus.frame_start_i) state <= STREAM;
                end
                STREAM: begin
                    if (transfer) begin
                        count <= count + CNT_BITS'(1);
                        if (count == FRAME_LAST) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            pr          <= '0;
            pg          <= '0;
            pb          <= '0;
            v1          <= 1'b0;
            px_gray     <= '0;
            gray_valid  <= 1'b0;
            sobel_start <= 1'b0;
        end else begin
            v1 <= transfer;
            if (transfer) begin
                pr <= 16'(r) * 16'd77;
                pg <= 16'(g) * 16'd150;
                pb <= 16'(b) * 16'd29;
            end
            gray_valid <= v1;
            if (v1) px_gray <= gray;
            // Drop start on the edge into DONE, right after the last gray pixel.
            if (state == FLUSH && flush_cnt) sobel_start <= 1'b0;
            else if (v1)                     sobel_start <= 1'b1;
        end
    end

    assign bus.px_ready_o    = px_ready;
    assign bus.px_gray_o     = px_gray;
    assign bus.gray_valid_o  = gray_valid;
    assign bus.sobel_start_o = sobel_start;
    assign bus.frame_done_o  = frame_done;

endmodule

// File: tb/tb_gray_stream_feeder.sv
// Scoreboard bench for gray_stream_feeder with 9-pixel frames.
// Directed RGB vectors; a negedge monitor pops and compares gray outputs.
module tb_gray_stream_feeder;

    logic clk_i = 1'b0;
    logic nreset_i = 1'b0;

    gray_stream_feeder_if #(.PIXEL_WIDTH_IN(24), .PIXEL_WIDTH_OUT(8)) bus ();

    gray_stream_feeder #(
        .PIXEL_WIDTH_IN (24),
        .PIXEL_WIDTH_OUT(8),
        .FRAME_PIXELS   (9)
    ) dut (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int g;
        int c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int   gray_cnt, sobel_cnt, done_cnt, max_gap, run, last_gray;

    logic [23:0] rgb_tab [9] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                                 24'h0000FF, 24'h000000, 24'h808080,
                                 24'h102030, 24'h0A0B0C, 24'h123456};
`ifdef GRAY_ROUND_EN
    int exp_tab [9] = '{255, 77, 149, 29, 0, 128, 29, 11, 46};
`else
    int exp_tab [9] = '{255, 76, 149, 28, 0, 128, 29, 10, 45};
`endif

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops, latency, hold and frame statistics.
    always @(negedge clk_i) begin
        if (nreset_i) begin
            if (bus.sobel_start_o) sobel_cnt++;
            if (bus.frame_done_o) done_cnt++;
            if (bus.gray_valid_o) begin
                exp_t e;
                gray_cnt++;
                chk("start_with_gray", int'(bus.sobel_start_o), 1);
                if (q.size() == 0) begin
                    chk("unexpected_gray", int'(bus.px_gray_o), -1);
                end else begin
                    e = q.pop_front();
                    chk("gray", int'(bus.px_gray_o), e.g);
                    chk("latency", cyc - e.c, 2);
                end
                if (run > max_gap) max_gap = run;
                run = 0;
                last_gray = int'(bus.px_gray_o);
            end else if (bus.sobel_start_o) begin
                run++;
                chk("gray_hold", int'(bus.px_gray_o), last_gray);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_stats();
        gray_cnt  = 0;
        sobel_cnt = 0;
        done_cnt  = 0;
        max_gap   = 0;
        run       = 0;
    endtask

    task automatic start_frame();
        clear_stats();
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
    endtask

    task automatic send_px(input int i);
        exp_t e;
        chk("ready_stream", int'(bus.px_ready_o), 1);
        bus.px_rgb_i   = rgb_tab[i];
        bus.px_valid_i = 1'b1;
        e.g = exp_tab[i];
        e.c = cyc;
        q.push_back(e);
        tick();
        bus.px_valid_i = 1'b0;
    endtask

    task automatic run_frame(input int stall_after, input int fs_at,
                             input bit misuse);
        start_frame();
        for (int i = 0; i < 9; i++) begin
            if (i == fs_at) bus.frame_start_i = 1'b1;
            send_px(i);
            bus.frame_start_i = 1'b0;
            if (i == stall_after) repeat (3) tick();
        end
        chk("ready_low_after_last", int'(bus.px_ready_o), 0);
        if (misuse) begin
            bus.px_rgb_i   = 24'hFFFFFF;
            bus.px_valid_i = 1'b1;
        end
        tick();
        chk("ready_low_flush", int'(bus.px_ready_o), 0);
        chk("done_early", int'(bus.frame_done_o), 0);
        chk("start_in_flush", int'(bus.sobel_start_o), 1);
        tick();
        chk("done_pulse", int'(bus.frame_done_o), 1);
        chk("start_cleared", int'(bus.sobel_start_o), 0);
        bus.px_valid_i = 1'b0;
        tick();
        chk("done_single", int'(bus.frame_done_o), 0);
        repeat (3) tick();
        chk("gray_count", gray_cnt, 9);
        chk("done_count", done_cnt, 1);
        chk("sobel_cycles", sobel_cnt, (stall_after >= 0) ? 12 : 9);
        chk("gray_gap", max_gap, (stall_after >= 0) ? 3 : 0);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        bus.frame_start_i = 1'b0;
        bus.px_rgb_i      = '0;
        bus.px_valid_i    = 1'b0;
        clear_stats();
        last_gray = 0;

        repeat (3) tick();
        chk("rst_ready", int'(bus.px_ready_o), 0);
        chk("rst_gray", int'(bus.px_gray_o), 0);
        chk("rst_valid", int'(bus.gray_valid_o), 0);
        chk("rst_start", int'(bus.sobel_start_o), 0);
        chk("rst_done", int'(bus.frame_done_o), 0);
        nreset_i = 1'b1;
        tick();
        chk("idle_ready", int'(bus.px_ready_o), 0);

        // Valid in IDLE must not enter the pipeline.
        bus.px_rgb_i   = 24'h808080;
        bus.px_valid_i = 1'b1;
        repeat (3) tick();
        bus.px_valid_i = 1'b0;
        repeat (2) tick();
        chk("idle_no_gray", gray_cnt, 0);

        run_frame(-1, -1, 1'b0);
        run_frame(3, -1, 1'b0);
        run_frame(-1, 3, 1'b1);

        // Reset after pixel 5, then a clean frame.
        start_frame();
        for (int i = 0; i < 5; i++) send_px(i);
        nreset_i = 1'b0;
        #1;
        chk("abort_ready", int'(bus.px_ready_o), 0);
        chk("abort_gray", int'(bus.px_gray_o), 0);
        chk("abort_valid", int'(bus.gray_valid_o), 0);
        chk("abort_start", int'(bus.sobel_start_o), 0);
        chk("abort_done", int'(bus.frame_done_o), 0);
        q.delete();
        last_gray = 0;
        tick();
        nreset_i = 1'b1;
        tick();
        chk("abort_idle", int'(bus.px_ready_o), 0);
        run_frame(-1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
